// File: rtl/adma_descriptor_engine.sv
// adma_descriptor_engine
//   Walks an ADMA2 descriptor table in system RAM. Each 96-bit descriptor is
//   fetched as three 32-bit words, decoded, and either handed to the transfer
//   stage as one data segment (start/direction/address_init/length) or
//   consumed in place (nop, reserved, zero-length tran, link).
// Ports:
//   CLK, RESET            clock (posedge) and asynchronous active-high reset
//   adma_start/adma_stop  walk start pulse / abort request
//   descriptor_base       byte address of the first descriptor
//   dir_mode              transfer direction copied to `direction`
//   ram_read/ram_address  descriptor word read port (data one cycle later)
//   data_from_ram         descriptor word read data
//   start/direction/address_init/length  segment handed to the transfer stage
//   TFC                   transfer complete from the transfer stage
//   adma_busy/adma_int/adma_done/adma_error  status
//   desc_pointer          address of the current descriptor
`timescale 1ns/1ps
module adma_descriptor_engine #(
  parameter int unsigned DESC_BYTES = 12
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        adma_start,
  input  logic        adma_stop,
  input  logic [63:0] descriptor_base,
  input  logic        dir_mode,
  output logic        ram_read,
  output logic [63:0] ram_address,
  input  logic [31:0] data_from_ram,
  output logic        start,
  output logic        direction,
  output logic [63:0] address_init,
  output logic [15:0] length,
  input  logic        TFC,
  output logic        adma_busy,
  output logic        adma_int,
  output logic        adma_done,
  output logic        adma_error,
  output logic [63:0] desc_pointer
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FDS  = 2'd1,
    ST_CADR = 2'd2,
    ST_TFR  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  word_cnt_r, word_cnt_nxt_s;
  logic [31:0] w0_r, w1_r, w2_r;
  logic        tfr_armed_r, tfr_armed_nxt_s;

  logic        ram_read_nxt_s;
  logic [63:0] ram_address_nxt_s;
  logic        start_nxt_s;
  logic        direction_nxt_s;
  logic [63:0] address_init_nxt_s;
  logic [15:0] length_nxt_s;
  logic        busy_nxt_s;
  logic        int_nxt_s;
  logic        done_nxt_s;
  logic        error_nxt_s;
  logic [63:0] ptr_nxt_s;

  // Descriptor fields decoded from the captured words
  logic        attr_valid_s, attr_end_s, attr_int_s;
  logic [1:0]  attr_act_s;
  logic [15:0] desc_len_s;
  logic [63:0] desc_addr_s;
  logic        is_link_s, is_xfer_s, tfc_done_s, complete_s;
  logic        unused_attr_s;

  assign attr_valid_s  = w0_r[0];
  assign attr_end_s    = w0_r[1];
  assign attr_int_s    = w0_r[2];
  assign attr_act_s    = w0_r[5:4];
  assign desc_len_s    = w0_r[31:16];
  assign desc_addr_s   = {w2_r, w1_r};
  assign unused_attr_s = ^{w0_r[15:6], w0_r[3]};

  assign is_link_s  = (attr_act_s == 2'b11);
  assign is_xfer_s  = (attr_act_s == 2'b10) && (desc_len_s != 16'd0);
  // The first TFR edge still sees the transfer stage's idle TFC, so it is masked.
  assign tfc_done_s = tfr_armed_r && TFC;
  // A descriptor finishes either directly in decode or when its segment ends.
  assign complete_s = !adma_stop &&
                      (((state_r == ST_CADR) && attr_valid_s && !is_xfer_s) ||
                       ((state_r == ST_TFR) && tfc_done_s));

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_STOP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything, including a start in ST_STOP
  always_comb begin
    state_nxt_s = state_r;
    if (adma_stop) begin
      state_nxt_s = ST_STOP;
    end else begin
      case (state_r)
        ST_STOP: if (adma_start) state_nxt_s = ST_FDS; else state_nxt_s = ST_STOP;
        ST_FDS:  if (word_cnt_r == 2'd3) state_nxt_s = ST_CADR; else state_nxt_s = ST_FDS;
        ST_CADR: begin
          if (!attr_valid_s)   state_nxt_s = ST_STOP;
          else if (is_xfer_s)  state_nxt_s = ST_TFR;
          else if (attr_end_s) state_nxt_s = ST_STOP;
          else                 state_nxt_s = ST_FDS;
        end
        ST_TFR: begin
          if (!tfc_done_s)     state_nxt_s = ST_TFR;
          else if (attr_end_s) state_nxt_s = ST_STOP;
          else                 state_nxt_s = ST_FDS;
        end
        default: state_nxt_s = ST_STOP;
      endcase
    end
  end

  // Output logic: next values for every registered output
  always_comb begin
    busy_nxt_s      = (state_nxt_s != ST_STOP);
    start_nxt_s     = (state_nxt_s == ST_TFR);
    tfr_armed_nxt_s = (state_r == ST_TFR) && (state_nxt_s == ST_TFR);
    int_nxt_s       = complete_s && attr_int_s;
    done_nxt_s      = complete_s && attr_end_s;

    if ((state_r == ST_FDS) && (state_nxt_s == ST_FDS)) begin
      word_cnt_nxt_s = word_cnt_r + 2'd1;
    end else begin
      word_cnt_nxt_s = 2'd0;
    end

    if ((state_r == ST_STOP) && adma_start && !adma_stop) begin
      ptr_nxt_s = descriptor_base;
    end else if (complete_s && is_link_s) begin
      ptr_nxt_s = desc_addr_s;
    end else if (complete_s && !attr_end_s) begin
      ptr_nxt_s = desc_pointer + 64'(DESC_BYTES);
    end else begin
      ptr_nxt_s = desc_pointer;
    end

    if ((state_r == ST_STOP) && adma_start && !adma_stop) begin
      error_nxt_s = 1'b0;
    end else if ((state_r == ST_CADR) && !attr_valid_s && !adma_stop) begin
      error_nxt_s = 1'b1;
    end else begin
      error_nxt_s = adma_error;
    end

    if ((state_r == ST_CADR) && (state_nxt_s == ST_TFR)) begin
      address_init_nxt_s = desc_addr_s;
      length_nxt_s       = desc_len_s;
      direction_nxt_s    = dir_mode;
    end else begin
      address_init_nxt_s = address_init;
      length_nxt_s       = length;
      direction_nxt_s    = direction;
    end

    // Reads go out on the first three fetch cycles: word 0 on entry, then +4, +8.
    if ((state_nxt_s == ST_FDS) && (state_r != ST_FDS)) begin
      ram_read_nxt_s    = 1'b1;
      ram_address_nxt_s = ptr_nxt_s;
    end else if ((state_nxt_s == ST_FDS) && (word_cnt_r == 2'd0)) begin
      ram_read_nxt_s    = 1'b1;
      ram_address_nxt_s = desc_pointer + 64'd4;
    end else if ((state_nxt_s == ST_FDS) && (word_cnt_r == 2'd1)) begin
      ram_read_nxt_s    = 1'b1;
      ram_address_nxt_s = desc_pointer + 64'd8;
    end else begin
      ram_read_nxt_s    = 1'b0;
      ram_address_nxt_s = ram_address;
    end
  end

  // Registered outputs, fetch counter and captured descriptor words
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      word_cnt_r   <= 2'd0;
      tfr_armed_r  <= 1'b0;
      w0_r         <= 32'd0;
      w1_r         <= 32'd0;
      w2_r         <= 32'd0;
      ram_read     <= 1'b0;
      ram_address  <= 64'd0;
      start        <= 1'b0;
      direction    <= 1'b0;
      address_init <= 64'd0;
      length       <= 16'd0;
      adma_busy    <= 1'b0;
      adma_int     <= 1'b0;
      adma_done    <= 1'b0;
      adma_error   <= 1'b0;
      desc_pointer <= 64'd0;
    end else begin
      word_cnt_r   <= word_cnt_nxt_s;
      tfr_armed_r  <= tfr_armed_nxt_s;
      ram_read     <= ram_read_nxt_s;
      ram_address  <= ram_address_nxt_s;
      start        <= start_nxt_s;
      direction    <= direction_nxt_s;
      address_init <= address_init_nxt_s;
      length       <= length_nxt_s;
      adma_busy    <= busy_nxt_s;
      adma_int     <= int_nxt_s;
      adma_done    <= done_nxt_s;
      adma_error   <= error_nxt_s;
      desc_pointer <= ptr_nxt_s;
      // Word k arrives during fetch cycle k+1 (one cycle after its read)
      if (state_r == ST_FDS) begin
        case (word_cnt_r)
          2'd1:    w0_r <= data_from_ram;
          2'd2:    w1_r <= data_from_ram;
          2'd3:    w2_r <= data_from_ram;
          default: w0_r <= w0_r;
        endcase
      end else begin
        w0_r <= w0_r;
      end
    end
  end

endmodule

// File: tb/tb_adma_descriptor_engine.sv
`timescale 1ns/1ps
module tb_adma_descriptor_engine;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        adma_start = 1'b0;
  logic        adma_stop = 1'b0;
  logic [63:0] descriptor_base = 64'd0;
  logic        dir_mode = 1'b0;
  logic        ram_read;
  logic [63:0] ram_address;
  logic [31:0] data_from_ram = 32'd0;
  logic        start;
  logic        direction;
  logic [63:0] address_init;
  logic [15:0] length;
  logic        TFC = 1'b1;
  logic        adma_busy, adma_int, adma_done, adma_error;
  logic [63:0] desc_pointer;

  adma_descriptor_engine #(.DESC_BYTES(12)) dut (
    .CLK(CLK), .RESET(RESET), .adma_start(adma_start), .adma_stop(adma_stop),
    .descriptor_base(descriptor_base), .dir_mode(dir_mode),
    .ram_read(ram_read), .ram_address(ram_address), .data_from_ram(data_from_ram),
    .start(start), .direction(direction), .address_init(address_init), .length(length),
    .TFC(TFC), .adma_busy(adma_busy), .adma_int(adma_int), .adma_done(adma_done),
    .adma_error(adma_error), .desc_pointer(desc_pointer)
  );

  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  // ---------------- scoreboard ----------------
  localparam int K_FETCH = 0;
  localparam int K_START = 1;
  localparam int K_INT   = 2;
  localparam int K_DONE  = 3;
  string kname [4] = '{"fetch", "start", "int", "done"};

  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;
  exp_t sb_q[$];

  task automatic sb_expect(input int kind, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic sb_match(input int kind, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({"sb_unexpected_", kname[kind]}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({"sb_kind_", kname[kind]}, 64'(kind), 64'(e.kind));
      chk({"sb_a_", kname[kind]}, a, e.a);
      chk({"sb_b_", kname[kind]}, b, e.b);
    end
  endtask

  // ---------------- RAM and transfer-stage models ----------------
  logic [31:0] mem [logic [63:0]];
  int tfc_delay = 4;
  int tfc_cnt   = 0;

  always @(posedge CLK) begin
    if (ram_read) data_from_ram <= mem.exists(ram_address) ? mem[ram_address] : 32'hDEAD_BEEF;
  end

  always @(posedge CLK) begin
    if (!start) begin
      tfc_cnt <= 0;
      TFC     <= 1'b1;
    end else begin
      tfc_cnt <= tfc_cnt + 1;
      TFC     <= (tfc_delay != 0) && (tfc_cnt + 1 == tfc_delay);
    end
  end

  // ---------------- monitor ----------------
  bit rr_prev = 1'b0;
  bit start_prev = 1'b0;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (ram_read && !rr_prev) sb_match(K_FETCH, ram_address, 64'd0);
      if (start && !start_prev) sb_match(K_START, address_init, {48'd0, length});
      if (adma_int)             sb_match(K_INT, desc_pointer, 64'd0);
      if (adma_done)            sb_match(K_DONE, desc_pointer, 64'd0);
    end
    rr_prev    <= ram_read;
    start_prev <= start;
  end

  // ---------------- helpers ----------------
  task automatic put_desc(input logic [63:0] a, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] w2);
    mem[a] = w0; mem[a + 64'd4] = w1; mem[a + 64'd8] = w2;
  endtask

  task automatic kick(input logic [63:0] base);
    descriptor_base = base;
    adma_start = 1'b1;
    @(negedge CLK);
    adma_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (adma_busy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_idle_in_time"}, 64'(n < 300), 64'd1);
    repeat (2) @(negedge CLK);
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, ram_address | address_init | desc_pointer, 64'd0);
    chk({tag, "_bits"}, {41'd0, length, ram_read, start, direction,
                         adma_busy, adma_int, adma_done, adma_error}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    int to;

    // single descriptor table @0x100 and its chain continuation
    put_desc(64'h100, 32'h0040_0023, 32'h0000_2000, 32'h0);
    put_desc(64'h200, 32'h0040_0020, 32'h0000_2000, 32'h0);   // Valid=0
    put_desc(64'h500, 32'h0008_0005, 32'h0, 32'h0);           // nop + Int
    put_desc(64'h50C, 32'h0000_0023, 32'h0000_6000, 32'h0);   // tran len 0, End

    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // ---- single-descriptor walk with latency checks ----
    dir_mode  = 1'b1;
    tfc_delay = 16;
    sb_expect(K_FETCH, 64'h100, 64'd0);
    sb_expect(K_START, 64'h2000, 64'h40);
    sb_expect(K_DONE, 64'h100, 64'd0);
    kick(64'h100);
    chk("t1_first_read", 64'(ram_read), 64'd1);
    chk("t1_first_addr", ram_address, 64'h100);
    repeat (4) @(negedge CLK);
    chk("t1_start_not_yet", 64'(start), 64'd0);
    @(negedge CLK);
    chk("t1_start_latency", 64'(start), 64'd1);
    hi = 0; to = 0;
    while (start && to < 100) begin
      hi++;
      @(negedge CLK);
      to++;
    end
    chk("t1_start_hold", 64'(hi), 64'd17);
    chk("t1_done_busy", 64'(adma_busy), 64'd0);
    chk("t1_direction", 64'(direction), 64'd1);
    wait_idle("t1");

    // ---- chain with link; a start while busy must be ignored ----
    put_desc(64'h100, 32'h0020_0021, 32'h0000_3000, 32'h0);
    put_desc(64'h10C, 32'h0000_0031, 32'h0000_0400, 32'h0);
    put_desc(64'h400, 32'h0010_0027, 32'h0000_5000, 32'h1);
    dir_mode  = 1'b0;
    tfc_delay = 4;
    sb_expect(K_FETCH, 64'h100, 64'd0);
    sb_expect(K_START, 64'h3000, 64'h20);
    sb_expect(K_FETCH, 64'h10C, 64'd0);
    sb_expect(K_FETCH, 64'h400, 64'd0);
    sb_expect(K_START, 64'h1_0000_5000, 64'h10);
    sb_expect(K_INT, 64'h400, 64'd0);
    sb_expect(K_DONE, 64'h400, 64'd0);
    kick(64'h100);
    repeat (8) @(negedge CLK);
    kick(64'h900);
    wait_idle("t2");
    chk("t2_direction", 64'(direction), 64'd0);
    chk("t2_ptr_final", desc_pointer, 64'h400);

    // ---- invalid descriptor, then restart clears the error ----
    sb_expect(K_FETCH, 64'h200, 64'd0);
    kick(64'h200);
    wait_idle("t3");
    chk("t3_error_set", 64'(adma_error), 64'd1);
    chk("t3_not_busy", 64'(adma_busy), 64'd0);
    put_desc(64'h100, 32'h0040_0023, 32'h0000_2000, 32'h0);
    sb_expect(K_FETCH, 64'h100, 64'd0);
    sb_expect(K_START, 64'h2000, 64'h40);
    sb_expect(K_DONE, 64'h100, 64'd0);
    kick(64'h100);
    chk("t3_error_cleared", 64'(adma_error), 64'd0);
    wait_idle("t3r");

    // ---- nop with Int, then zero-length tran with End ----
    sb_expect(K_FETCH, 64'h500, 64'd0);
    sb_expect(K_FETCH, 64'h50C, 64'd0);
    sb_expect(K_INT, 64'h50C, 64'd0);
    sb_expect(K_DONE, 64'h50C, 64'd0);
    kick(64'h500);
    wait_idle("t4");

    // ---- abort three cycles into the transfer ----
    tfc_delay = 0;
    sb_expect(K_FETCH, 64'h100, 64'd0);
    sb_expect(K_START, 64'h2000, 64'h40);
    kick(64'h100);
    to = 0;
    while (!start && to < 30) begin
      @(negedge CLK);
      to++;
    end
    chk("t5_start_seen", 64'(start), 64'd1);
    repeat (2) @(negedge CLK);
    adma_stop = 1'b1;
    @(negedge CLK);
    adma_stop = 1'b0;
    chk("t5_start_dropped", 64'(start), 64'd0);
    chk("t5_not_busy", 64'(adma_busy), 64'd0);
    chk("t5_no_error", 64'(adma_error), 64'd0);
    wait_idle("t5");

    // ---- start and stop together in ST_STOP: stop wins ----
    descriptor_base = 64'h100;
    adma_start = 1'b1;
    adma_stop  = 1'b1;
    @(negedge CLK);
    adma_start = 1'b0;
    adma_stop  = 1'b0;
    chk("t6_stop_wins_busy", 64'(adma_busy), 64'd0);
    chk("t6_stop_wins_read", 64'(ram_read), 64'd0);
    wait_idle("t6");

    // ---- asynchronous reset in the second fetch cycle ----
    tfc_delay = 4;
    sb_expect(K_FETCH, 64'h100, 64'd0);
    kick(64'h100);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("t7_reset_mid_fetch");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    sb_expect(K_FETCH, 64'h100, 64'd0);
    sb_expect(K_START, 64'h2000, 64'h40);
    sb_expect(K_DONE, 64'h100, 64'd0);
    kick(64'h100);
    wait_idle("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
